tc1_spi_reader: RTL and testbench
=================================

Name: tc1_spi_reader

Overview:
- Receive-only SPI master for the MAX31855 on the Pmod TC1.
- On a measure request it clocks in one 32-bit frame, splits it into its fields and holds them in output registers.
- It sits directly upstream of the tc1 AXI-Lite register block. That block drives measure from its update timer or a software request, and consumes valid and the decoded fields.

Parameters:
- CLK_DIV, 10, clk cycles per SCLK half-period (default gives 5 MHz SCLK from a 100 MHz clk); legal range 1 or more.
- CS_SETUP, 10, clk cycles CSn is held low before the first SCLK rise; legal range 1 or more.
- CS_IDLE, 20, minimum clk cycles CSn stays high after a frame before a new measure is accepted; legal range 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- measure  in  1  start request, sampled only while idle
- SCLK  out  1  SPI clock to the sensor; idles low
- CSn  out  1  sensor chip select, active low
- MISO  in  1  serial data from the sensor, MSB first
- busy  out  1  high from the accepting edge until the block is back in IDLE
- valid  out  1  one-cycle pulse when new fields are loaded
- junc_t  out  14  thermocouple temperature, frame bits [31:18], two's complement, 0.25 C/LSB
- fault_main  out  1  frame bit 16
- internal_t  out  12  reference junction temperature, frame bits [15:4], two's complement, 0.0625 C/LSB
- faults  out  3  frame bits [2:0] = {SCV, SCG, OC}
- frame_err  out  1  reserved bit 17 or bit 3 was read as 1

Behaviour:
- Reset (async, active-high): CSn=1, SCLK=0, busy=0, valid=0, all field outputs 0, frame_err=0, state=IDLE. This applies immediately, including mid-frame. An aborted frame never raises valid.
- States: IDLE, SETUP, SHIFT, DONE, HOLD.
- IDLE: measure=1 at edge E0 sets CSn<=0, busy<=1, state<=SETUP. measure is ignored in every other state; there is no queueing.
- SETUP: lasts CS_SETUP cycles with SCLK=0, then goes to SHIFT.
- SHIFT: 32 bit periods, each CLK_DIV cycles low then CLK_DIV cycles high. Total 64*CLK_DIV cycles.
  - At the edge that drives SCLK 0->1, MISO is shifted into a 32-bit register MSB first. The sensor updates MISO on SCLK falling edges.
  - A 5-bit bit counter counts from 0 to 31.
  - A divide counter of $clog2(CLK_DIV+1) bits wraps at CLK_DIV-1.
  - At the edge ending the 32nd high phase: SCLK<=0, state<=DONE.
- DONE (one cycle):
  - CSn<=1.
  - Field outputs are loaded from the shift register.
  - frame_err <= bit17 | bit3.
  - valid<=1 for exactly one cycle.
  - state<=HOLD.
- Field outputs hold their values until the next completed frame.
- HOLD: counts CS_IDLE cycles with CSn=1, then IDLE with busy<=0.
- Timing:
  - valid is high in the cycle after edge E0 + CS_SETUP + 64*CLK_DIV + 1.
  - The earliest next accept edge is CS_IDLE + 1 edges after the DONE edge.
  - Minimum measure-to-measure period = CS_SETUP + 64*CLK_DIV + CS_IDLE + 2 cycles.
- measure held high continuously gives back-to-back frames at exactly that period.
- Glitch-free outputs: SCLK and CSn are driven straight from flops. CSn never changes while SCLK=1.
- There are no arithmetic conversions; fields are passed through as raw bit slices.

Decomposition:
- Package tc1_pkg:
  - state enum (IDLE, SETUP, SHIFT, DONE, HOLD);
  - FRAME_W=32;
  - field slice constants (JUNC_MSB=31, JUNC_LSB=18, RSV1=17, FAULT=16, INT_MSB=15, INT_LSB=4, RSV0=3, SCV=2, SCG=1, OC=0).
- One sub-module, tc1_sclk_gen:
  - divide counter plus SCLK toggle;
  - enable input, plus rise/fall strobes to the FSM.
- The FSM, shift register and field registers stay in tc1_spi_reader.

Test Plan:
1. Sensor model shifts on negedge SCLK while CSn=0, loaded with {14'hBA5,0,0,12'hAFE,0,3'b000}; pulse measure -> one valid pulse at edge E0+CS_SETUP+64*CLK_DIV+1; junc_t=14'hBA5, internal_t=12'hAFE, faults=0, fault_main=0, frame_err=0; exactly 32 SCLK rises seen while CSn=0.
2. Frame {14'h111,0,1,12'h1C0,0,3'b001} -> fault_main=1, faults=3'b001, junc_t=14'h111, internal_t=12'h1C0.
3. Frame with bit17=1 and bit3=1 -> frame_err=1. The next clean frame -> frame_err=0.
4. measure pulsed during SHIFT and during HOLD -> ignored: no extra frame, CSn high time at least CS_IDLE. measure held high -> frames repeat every CS_SETUP+64*CLK_DIV+CS_IDLE+2 cycles.
5. rst asserted at bit 15 of SHIFT -> CSn=1 and SCLK=0 within the same cycle, outputs 0, no valid. A following measure reads a full correct frame.
6. CLK_DIV=1, CS_SETUP=1, CS_IDLE=1 -> SCLK period 2 clk; frame 32'hFFFFFFFF gives junc_t=14'h3FFF, internal_t=12'hFFF, faults=3'b111, frame_err=1.

Source files
------------

// File: rtl/tc1_pkg.sv
// tc1_pkg: FSM encoding and MAX31855 frame layout shared by the Pmod TC1 reader
package tc1_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;
   localparam int FRAME_W  = 32;
   localparam int JUNC_MSB = 31;
   localparam int JUNC_LSB = 18;
   localparam int RSV1     = 17;
   localparam int FAULT    = 16;
   localparam int INT_MSB  = 15;
   localparam int INT_LSB  = 4;
   localparam int RSV0     = 3;
   localparam int SCV      = 2;
   localparam int SCG      = 1;
   localparam int OC       = 0;
endpackage

// File: rtl/tc1_sclk_gen.sv
// tc1_sclk_gen: SCLK divider with strobes marking the edges that flip SCLK
module tc1_sclk_gen #(
   parameter int CLK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);
   localparam int DW = $clog2(CLK_DIV + 1);
   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d, wrap;
   always_comb begin
      wrap   = en && (div_q == DW'(CLK_DIV - 1));
      rise   = wrap && !sclk_q;
      fall   = wrap && sclk_q;
      div_d  = (en && !wrap) ? div_q + 1'b1 : '0;
      sclk_d = en && (sclk_q ^ wrap);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end
   assign sclk = sclk_q;
endmodule

// File: rtl/tc1_spi_reader.sv
// tc1_spi_reader: receive-only SPI master that reads one MAX31855 frame per measure request
module tc1_spi_reader
   import tc1_pkg::*;
#(
   parameter int CLK_DIV  = 10,
   parameter int CS_SETUP = 10,
   parameter int CS_IDLE  = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        measure,
   output logic        SCLK,
   output logic        CSn,
   input  logic        MISO,
   output logic        busy,
   output logic        valid,
   output logic [13:0] junc_t,
   output logic        fault_main,
   output logic [11:0] internal_t,
   output logic [2:0]  faults,
   output logic        frame_err
);
   localparam int CNT_W = $clog2((CS_SETUP > CS_IDLE ? CS_SETUP : CS_IDLE) + 1);
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         bit_q, bit_d;
   logic [FRAME_W-1:0] sr_q, sr_d;
   logic               csn_q, csn_d, valid_q, valid_d;
   logic [13:0]        junc_t_q, junc_t_d;
   logic               fault_main_q, fault_main_d, frame_err_q, frame_err_d;
   logic [11:0]        internal_t_q, internal_t_d;
   logic [2:0]         faults_q, faults_d;
   logic               rise, fall;
   tc1_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == SHIFT),
      .sclk (SCLK),
      .rise (rise),
      .fall (fall)
   );
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      sr_d         = sr_q;
      csn_d        = csn_q;
      valid_d      = 1'b0;
      junc_t_d     = junc_t_q;
      fault_main_d = fault_main_q;
      internal_t_d = internal_t_q;
      faults_d     = faults_q;
      frame_err_d  = frame_err_q;
      case (state_q)
         IDLE: if (measure) begin
            state_d = SETUP;
            csn_d   = 1'b0;
            cnt_d   = '0;
         end
         SETUP: if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bit_d   = '0;
         end else cnt_d = cnt_q + 1'b1;
         SHIFT: begin
            if (rise) sr_d = {sr_q[FRAME_W-2:0], MISO};
            // the falling edge closes a bit period; the 32nd one ends the frame
            if (fall) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 5'd31) state_d = DONE;
            end
         end
         DONE: begin
            csn_d        = 1'b1;
            valid_d      = 1'b1;
            junc_t_d     = sr_q[JUNC_MSB:JUNC_LSB];
            fault_main_d = sr_q[FAULT];
            internal_t_d = sr_q[INT_MSB:INT_LSB];
            faults_d     = {sr_q[SCV], sr_q[SCG], sr_q[OC]};
            frame_err_d  = sr_q[RSV1] | sr_q[RSV0];
            cnt_d        = '0;
            state_d      = HOLD;
         end
         HOLD: if (cnt_q == CNT_W'(CS_IDLE - 1)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         sr_q         <= '0;
         csn_q        <= 1'b1;
         valid_q      <= 1'b0;
         junc_t_q     <= '0;
         fault_main_q <= 1'b0;
         internal_t_q <= '0;
         faults_q     <= '0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         sr_q         <= sr_d;
         csn_q        <= csn_d;
         valid_q      <= valid_d;
         junc_t_q     <= junc_t_d;
         fault_main_q <= fault_main_d;
         internal_t_q <= internal_t_d;
         faults_q     <= faults_d;
         frame_err_q  <= frame_err_d;
      end
   end
   assign CSn        = csn_q;
   assign busy       = state_q != IDLE;
   assign valid      = valid_q;
   assign junc_t     = junc_t_q;
   assign fault_main = fault_main_q;
   assign internal_t = internal_t_q;
   assign faults     = faults_q;
   assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_tc1_spi_reader.sv
// tb_tc1_spi_reader: scoreboard bench with a MAX31855 sensor model on two parameterisations
module tb_tc1_spi_reader;
   localparam int CD  = 10, CSS = 10, CSI = 20;
   localparam int LAT = CSS + 64 * CD + 2;
   localparam int PER = CSS + 64 * CD + CSI + 2;
   typedef struct packed {logic [13:0] j; logic r17; logic fm; logic [11:0] it; logic r3; logic [2:0] f;} vec_t;
   typedef struct packed {logic [13:0] j; logic fm; logic [11:0] it; logic [2:0] f; logic fe;} fields_t;
   typedef struct {fields_t f; int cyc;} ev_t;

   logic clk = 0, rst = 0, meas_a = 0, meas_b = 0, miso_a = 0, miso_b = 0;
   logic sclk_a, csn_a, busy_a, valid_a, fm_a, fe_a;
   logic sclk_b, csn_b, busy_b, valid_b, fm_b, fe_b;
   logic [13:0] j_a, j_b;
   logic [11:0] it_a, it_b;
   logic [2:0]  f_a, f_b;
   logic [31:0] sens_a = '0, sens_b = '0, sh_a = '0, sh_b = '0;
   logic        csn_prev = 1'b1;
   int cyc = 0, rises_a = 0, rises_b = 0, vcnt_a = 0, vcnt_b = 0, up_a = 0, hi_a = 0;
   int n_vec = 0, n_bad = 0;
   ev_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
   vec_t tbl[4] = '{
      '{14'hBA5, 1'b0, 1'b0, 12'hAFE, 1'b0, 3'b000},
      '{14'h111, 1'b0, 1'b1, 12'h1C0, 1'b0, 3'b001},
      '{14'h2A5, 1'b1, 1'b0, 12'h123, 1'b1, 3'b010},
      '{14'h0F0, 1'b0, 1'b0, 12'h00F, 1'b0, 3'b100}
   };

   tc1_spi_reader dut_a (
      .clk(clk), .rst(rst), .measure(meas_a), .SCLK(sclk_a), .CSn(csn_a), .MISO(miso_a),
      .busy(busy_a), .valid(valid_a), .junc_t(j_a), .fault_main(fm_a), .internal_t(it_a),
      .faults(f_a), .frame_err(fe_a));
   tc1_spi_reader #(.CLK_DIV(1), .CS_SETUP(1), .CS_IDLE(1)) dut_b (
      .clk(clk), .rst(rst), .measure(meas_b), .SCLK(sclk_b), .CSn(csn_b), .MISO(miso_b),
      .busy(busy_b), .valid(valid_b), .junc_t(j_b), .fault_main(fm_b), .internal_t(it_b),
      .faults(f_b), .frame_err(fe_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // sensor presents the MSB when selected and advances on each SCLK fall
   always @(negedge csn_a) begin sh_a = sens_a; miso_a = sh_a[31]; end
   always @(negedge sclk_a) if (csn_a === 1'b0) begin sh_a = sh_a << 1; miso_a = sh_a[31]; end
   always @(posedge sclk_a) if (csn_a === 1'b0) rises_a++;
   always @(negedge csn_b) begin sh_b = sens_b; miso_b = sh_b[31]; end
   always @(negedge sclk_b) if (csn_b === 1'b0) begin sh_b = sh_b << 1; miso_b = sh_b[31]; end
   always @(posedge sclk_b) if (csn_b === 1'b0) rises_b++;

   always @(negedge clk) begin
      if (valid_a === 1'b1) begin
         obs_a.push_back('{f: fields_t'({j_a, fm_a, it_a, f_a, fe_a}), cyc: cyc});
         vcnt_a++;
      end
      if (valid_b === 1'b1) begin
         obs_b.push_back('{f: fields_t'({j_b, fm_b, it_b, f_b, fe_b}), cyc: cyc});
         vcnt_b++;
      end
      if (csn_a === 1'b1 && csn_prev === 1'b0) up_a = cyc;
      if (csn_a === 1'b0 && csn_prev === 1'b1) hi_a = cyc - up_a;
      csn_prev = csn_a;
   end

   function automatic fields_t expect_of(input vec_t v);
      return fields_t'({v.j, v.fm, v.it, v.f, v.r17 | v.r3});
   endfunction

   task automatic start_a(input vec_t v);
      ev_t e;
      int  k = 0;
      @(negedge clk);
      while (busy_a !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
      n_vec++;
      if (busy_a !== 1'b0) begin n_bad++; $display("FAIL start_idle: busy=%b required 0", busy_a); end
      sens_a = v;
      meas_a = 1'b1;
      e.f = expect_of(v);
      e.cyc = cyc + LAT;
      exp_a.push_back(e);
      @(negedge clk);
      meas_a = 1'b0;
   endtask

   task automatic wait_obs_a(input int n, input int budget, output bit ok);
      int k = 0;
      while (obs_a.size() < n && k < budget) begin @(negedge clk); k++; end
      ok = obs_a.size() >= n;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         n_vec++; if (csn_a !== 1'b1) begin n_bad++; $display("FAIL reset_csn[%0d]: got %b required 1", p, csn_a); end
         n_vec++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL reset_sclk[%0d]: got %b required 0", p, sclk_a); end
         n_vec++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_valid[%0d]: got %b%b required 00", p, busy_a, valid_a); end
         n_vec++; if ({j_a, fm_a, it_a, f_a, fe_a} !== 31'd0) begin n_bad++; $display("FAIL reset_fields[%0d]: got %h required 0", p, {j_a, fm_a, it_a, f_a, fe_a}); end
         rst = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_fields;
      ev_t e, o;
      bit  ok;
      int  r0, v0;
      for (int i = 0; i < 4; i++) begin
         exp_a.delete(); obs_a.delete();
         r0 = rises_a; v0 = vcnt_a;
         start_a(tbl[i]);
         wait_obs_a(1, LAT + 100, ok);
         repeat (3) @(negedge clk);
         n_vec++;
         if (!ok) begin n_bad++; $display("FAIL fields[%0d]_timeout: no valid within %0d cycles", i, LAT + 100); end
         else begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            n_vec++; if (o.f !== e.f) begin n_bad++; $display("FAIL fields[%0d]: got %h required %h", i, o.f, e.f); end
            n_vec++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL fields[%0d]_latency: valid at %0d required %0d", i, o.cyc, e.cyc); end
         end
         n_vec++; if (rises_a - r0 !== 32) begin n_bad++; $display("FAIL fields[%0d]_rises: got %0d required 32", i, rises_a - r0); end
         n_vec++; if (vcnt_a - v0 !== 1) begin n_bad++; $display("FAIL fields[%0d]_valid_cycles: got %0d required 1", i, vcnt_a - v0); end
      end
   endtask

   task automatic test_ignore;
      ev_t e, o;
      bit  ok;
      int  v0;
      exp_a.delete(); obs_a.delete();
      v0 = vcnt_a;
      start_a(tbl[1]);
      repeat (CSS + 20 * CD) @(negedge clk);
      meas_a = 1'b1; @(negedge clk); meas_a = 1'b0;
      wait_obs_a(1, LAT + 100, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL ignore_timeout: no valid within %0d cycles", LAT + 100); end
      else begin
         e = exp_a.pop_front(); o = obs_a.pop_front();
         n_vec++; if (o.f !== e.f) begin n_bad++; $display("FAIL ignore_fields: got %h required %h", o.f, e.f); end
      end
      repeat (5) @(negedge clk);
      meas_a = 1'b1; @(negedge clk); meas_a = 1'b0;
      repeat (CSI + 100) @(negedge clk);
      n_vec++; if (vcnt_a - v0 !== 1) begin n_bad++; $display("FAIL ignore_frames: got %0d valid cycles required 1", vcnt_a - v0); end
      n_vec++; if (csn_a !== 1'b1 || busy_a !== 1'b0) begin n_bad++; $display("FAIL ignore_idle: csn=%b busy=%b required 1 0", csn_a, busy_a); end
   endtask

   task automatic test_back_to_back;
      ev_t e, o;
      bit  ok;
      int  c;
      exp_a.delete(); obs_a.delete();
      sens_a = tbl[1];
      @(negedge clk);
      meas_a = 1'b1;
      c = cyc;
      e.f = expect_of(tbl[1]);
      e.cyc = c + LAT; exp_a.push_back(e);
      e.cyc = c + LAT + PER; exp_a.push_back(e);
      wait_obs_a(2, LAT + PER + 100, ok);
      meas_a = 1'b0;
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL b2b_timeout: %0d of 2 frames seen", obs_a.size()); end
      else for (int i = 0; i < 2; i++) begin
         e = exp_a.pop_front(); o = obs_a.pop_front();
         n_vec++; if (o.f !== e.f) begin n_bad++; $display("FAIL b2b[%0d]_fields: got %h required %h", i, o.f, e.f); end
         n_vec++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL b2b[%0d]_timing: valid at %0d required %0d", i, o.cyc, e.cyc); end
      end
      n_vec++; if (hi_a !== CSI + 1) begin n_bad++; $display("FAIL b2b_csn_high: got %0d cycles required %0d", hi_a, CSI + 1); end
      repeat (CSI + 5) @(negedge clk);
   endtask

   task automatic test_reset_abort;
      ev_t e, o;
      bit  ok;
      int  k = 0, v0;
      exp_a.delete(); obs_a.delete();
      v0 = vcnt_a;
      start_a(tbl[3]);
      while (rises_a < 16 + k * 0 && k < 0) k++;
      k = 0;
      begin
         int r0 = rises_a;
         while (rises_a - r0 < 16 && k < LAT) begin @(negedge clk); k++; end
      end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (csn_a !== 1'b1 || sclk_a !== 1'b0) begin n_bad++; $display("FAIL abort_pins: csn=%b sclk=%b required 1 0", csn_a, sclk_a); end
      n_vec++; if ({j_a, fm_a, it_a, f_a, fe_a} !== 31'd0) begin n_bad++; $display("FAIL abort_fields: got %h required 0", {j_a, fm_a, it_a, f_a, fe_a}); end
      n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy_a); end
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT) @(negedge clk);
      n_vec++; if (vcnt_a !== v0 || obs_a.size() != 0) begin n_bad++; $display("FAIL abort_valid: got %0d pulses required 0", vcnt_a - v0); end
      exp_a.delete(); obs_a.delete();
      start_a(tbl[2]);
      wait_obs_a(1, LAT + 100, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL abort_recover_timeout: no valid within %0d cycles", LAT + 100); end
      else begin
         e = exp_a.pop_front(); o = obs_a.pop_front();
         n_vec++; if (o.f !== e.f) begin n_bad++; $display("FAIL abort_recover: got %h required %h", o.f, e.f); end
         n_vec++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL abort_recover_latency: valid at %0d required %0d", o.cyc, e.cyc); end
      end
   endtask

   task automatic test_min_params;
      ev_t e, o;
      int  c, k = 0, r0;
      exp_b.delete(); obs_b.delete();
      r0 = rises_b;
      sens_b = '1;
      @(negedge clk);
      meas_b = 1'b1;
      c = cyc;
      e.f = fields_t'({14'h3FFF, 1'b1, 12'hFFF, 3'b111, 1'b1});
      e.cyc = c + 67; exp_b.push_back(e);
      e.cyc = c + 67 + 68; exp_b.push_back(e);
      while (obs_b.size() < 2 && k < 400) begin @(negedge clk); k++; end
      meas_b = 1'b0;
      n_vec++;
      if (obs_b.size() < 2) begin n_bad++; $display("FAIL min_timeout: %0d of 2 frames seen", obs_b.size()); end
      else for (int i = 0; i < 2; i++) begin
         e = exp_b.pop_front(); o = obs_b.pop_front();
         n_vec++; if (o.f !== e.f) begin n_bad++; $display("FAIL min[%0d]_fields: got %h required %h", i, o.f, e.f); end
         n_vec++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL min[%0d]_timing: valid at %0d required %0d", i, o.cyc, e.cyc); end
      end
      n_vec++; if (rises_b - r0 !== 64) begin n_bad++; $display("FAIL min_rises: got %0d required 64", rises_b - r0); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_fields;
      test_ignore;
      test_back_to_back;
      test_reset_abort;
      test_min_params;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
